// File: rtl/pwm_multi_channel.sv
// ----------------------------------------------------------------------------
// pwm_multi_channel
//   N-channel PWM generator with one shared, prescaled period counter.
//   Configuration (period, per-channel duty and enable) is written into shadow
//   registers through a valid/ready port. The shadow registers are copied into
//   the active registers only at a period boundary, so a period in progress is
//   never cut short or stretched. While stopped (run=0) a pending configuration
//   is applied on the next cycle.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous reset, active-low
//   run           1 = counter runs, 0 = counter held at 0 and outputs low
//   cfg_valid     a configuration word is present
//   cfg_ready     a configuration word can be accepted (no commit pending)
//   cfg_period    new period value P (the period lasts P+1 ticks)
//   cfg_duty      new duties, channel i in bits [i*CNT_W +: CNT_W]
//   cfg_en        new per-channel enables
//   pwm_out       registered PWM outputs
//   period_start  one-cycle pulse on the cycle after each period boundary
//
// Build option
//   PWM_CENTER_ALIGN_EN  when defined, the counter runs up 0..P and back down
//                        to 0 (2*P ticks per period) for centre-aligned pulses.
// ----------------------------------------------------------------------------
module pwm_multi_channel #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 16,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_PERIOD = 999
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  run,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_W-1:0]      cfg_period,
  input  logic [N_CH*CNT_W-1:0] cfg_duty,
  input  logic [N_CH-1:0]       cfg_en,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  period_start
);

  localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_INIT = CNT_W'(DEFAULT_PERIOD);

  // Counter state
  logic [PS_W-1:0]       r_presc;
  logic [CNT_W-1:0]      r_cnt;
`ifdef PWM_CENTER_ALIGN_EN
  logic                  r_dir_down;
  logic                  w_dir_next;
`endif

  // Active configuration
  logic [CNT_W-1:0]      r_period_q;
  logic [N_CH*CNT_W-1:0] r_duty_q;
  logic [N_CH-1:0]       r_en_q;

  // Shadow configuration
  logic [CNT_W-1:0]      r_sh_period;
  logic [N_CH*CNT_W-1:0] r_sh_duty;
  logic [N_CH-1:0]       r_sh_en;
  logic                  r_pending;

  // Registered outputs
  logic [N_CH-1:0]       r_pwm;
  logic                  r_period_start;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_accept;
  logic                  w_commit;
  logic [PS_W-1:0]       w_presc_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [N_CH-1:0]       w_pwm_next;

  assign cfg_ready    = !r_pending;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;

  assign w_tick   = run && (r_presc == PS_LAST);
  assign w_accept = cfg_valid && !r_pending;
  // When stopped there is no boundary to wait for, so commit right away.
  assign w_commit = r_pending && (!run || w_boundary);

  always_comb begin
    w_presc_next = r_presc + PS_W'(1);
    if (!run || w_tick) begin
      w_presc_next = '0;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    w_boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    w_dir_next = r_dir_down;
    if (!run) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
    end else if (w_tick) begin
      if (r_period_q == '0) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else if (r_dir_down) begin
        w_cnt_next = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_boundary = 1'b1;
          w_dir_next = 1'b0;
        end
      end else if (r_cnt >= r_period_q) begin
        // Turn around at the top. With P=1 the turn-around step is itself
        // the 1->0 step, so it is the boundary and the flag stays "up".
        w_cnt_next = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_boundary = 1'b1;
        end else begin
          w_dir_next = 1'b1;
        end
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end
`else
    if (!run) begin
      w_cnt_next = '0;
    end else if (w_tick) begin
      if (r_cnt == r_period_q) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end
`endif
  end

  // Per-channel compare against the shared counter; all channels are
  // phase-aligned at cnt=0.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_pwm_next[gi] = run && r_en_q[gi] &&
                            (r_cnt < r_duty_q[gi*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_presc        <= '0;
      r_cnt          <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      r_dir_down     <= 1'b0;
`endif
      r_period_q     <= PER_INIT;
      r_duty_q       <= '0;
      r_en_q         <= '0;
      r_sh_period    <= PER_INIT;
      r_sh_duty      <= '0;
      r_sh_en        <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_presc_next;
      r_cnt          <= w_cnt_next;
`ifdef PWM_CENTER_ALIGN_EN
      r_dir_down     <= w_dir_next;
`endif
      r_pwm          <= w_pwm_next;
      r_period_start <= w_boundary;
      // Accept needs !pending and commit needs pending, so they never
      // coincide; an accept on a boundary cycle therefore waits for the
      // following boundary.
      if (w_accept) begin
        r_sh_period <= cfg_period;
        r_sh_duty   <= cfg_duty;
        r_sh_en     <= cfg_en;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_period_q  <= r_sh_period;
        r_duty_q    <= r_sh_duty;
        r_en_q      <= r_sh_en;
        r_pending   <= 1'b0;
      end
    end
  end

endmodule
